// File: rtl/fmap_pkg.sv
// Shared constants, beat type and FSM state encoding for the feature-map read streamer.
package fmap_pkg;

  localparam int FMAP_ADDR_W    = 13;
  localparam int FMAP_BANK_W    = 64;
  localparam int FMAP_NUM_BANKS = 16;
  localparam int FMAP_DEPTH     = 8192;
  localparam int FMAP_BEAT_W    = FMAP_BANK_W * FMAP_NUM_BANKS;
  localparam int FMAP_LEN_W     = $clog2(FMAP_DEPTH) + 1;

  typedef struct packed {
    logic [FMAP_BEAT_W-1:0] data;
    logic                   last;
  } fmap_beat_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fmap_state_e;

endpackage

// File: rtl/fmap_rd_streamer_if.sv
// Buffer read port plus valid/ready beat stream; master is the streamer side.
interface fmap_rd_streamer_if;
  import fmap_pkg::*;

  logic                   fmap_rd_en;
  logic [FMAP_ADDR_W-1:0] fmap_rd_addr;
  logic [FMAP_BANK_W-1:0] fmap_rd_data_bank_0,  fmap_rd_data_bank_1,  fmap_rd_data_bank_2,  fmap_rd_data_bank_3;
  logic [FMAP_BANK_W-1:0] fmap_rd_data_bank_4,  fmap_rd_data_bank_5,  fmap_rd_data_bank_6,  fmap_rd_data_bank_7;
  logic [FMAP_BANK_W-1:0] fmap_rd_data_bank_8,  fmap_rd_data_bank_9,  fmap_rd_data_bank_10, fmap_rd_data_bank_11;
  logic [FMAP_BANK_W-1:0] fmap_rd_data_bank_12, fmap_rd_data_bank_13, fmap_rd_data_bank_14, fmap_rd_data_bank_15;
  logic                   m_valid;
  logic                   m_ready;
  logic [FMAP_BEAT_W-1:0] m_data;
  logic                   m_last;

  modport master (
    output fmap_rd_en, fmap_rd_addr, m_valid, m_data, m_last,
    input  fmap_rd_data_bank_0,  fmap_rd_data_bank_1,  fmap_rd_data_bank_2,  fmap_rd_data_bank_3,
           fmap_rd_data_bank_4,  fmap_rd_data_bank_5,  fmap_rd_data_bank_6,  fmap_rd_data_bank_7,
           fmap_rd_data_bank_8,  fmap_rd_data_bank_9,  fmap_rd_data_bank_10, fmap_rd_data_bank_11,
           fmap_rd_data_bank_12, fmap_rd_data_bank_13, fmap_rd_data_bank_14, fmap_rd_data_bank_15,
           m_ready
  );

  modport slave (
    input  fmap_rd_en, fmap_rd_addr, m_valid, m_data, m_last,
    output fmap_rd_data_bank_0,  fmap_rd_data_bank_1,  fmap_rd_data_bank_2,  fmap_rd_data_bank_3,
           fmap_rd_data_bank_4,  fmap_rd_data_bank_5,  fmap_rd_data_bank_6,  fmap_rd_data_bank_7,
           fmap_rd_data_bank_8,  fmap_rd_data_bank_9,  fmap_rd_data_bank_10, fmap_rd_data_bank_11,
           fmap_rd_data_bank_12, fmap_rd_data_bank_13, fmap_rd_data_bank_14, fmap_rd_data_bank_15,
           m_ready
  );

endinterface

// File: rtl/fmap_rd_skid_fifo.sv
// Two-entry beat FIFO; the caller guarantees no push when full and no pop when empty.
module fmap_rd_skid_fifo
  import fmap_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  fmap_beat_t push_beat,
  input  logic       pop,
  output fmap_beat_t head,
  output logic [1:0] count
);

  fmap_beat_t mem_q [2];
  fmap_beat_t mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_beat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Storage is reset too so the stream data bus reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fmap_rd_streamer.sv
// Walks a (strided, with FMAP_RD_STRIDE_EN) address range of the 16-bank buffer and
// streams each 1024-bit read as one beat; reads only issue when the FIFO can land them.
module fmap_rd_streamer
  import fmap_pkg::*;
(
  input  logic                   core_clk,
  input  logic                   core_rst_n,
  input  logic                   start,
  input  logic [FMAP_ADDR_W-1:0] base_addr,
  input  logic [FMAP_LEN_W-1:0]  length,
`ifdef FMAP_RD_STRIDE_EN
  input  logic [FMAP_ADDR_W-1:0] stride,
`endif
  output logic                   busy,
  output logic                   done,
  fmap_rd_streamer_if.master     bus
);

  fmap_state_e            state_q, state_d;
  logic [FMAP_ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [FMAP_ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [FMAP_ADDR_W-1:0] cur_stride;
  logic [FMAP_LEN_W-1:0]  length_q, length_d;
  logic [FMAP_LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic                   inflight_q, inflight_d;
  logic                   last_tag_q, last_tag_d;
  logic                   issue;
  logic                   pop;
  logic                   m_valid;
  logic [2:0]             pending;
  logic [1:0]             fifo_count;
  fmap_beat_t             head;
  fmap_beat_t             push_beat;

`ifdef FMAP_RD_STRIDE_EN
  logic [FMAP_ADDR_W-1:0] stride_q, stride_d;
  assign cur_stride = stride_q;
`else
  assign cur_stride = FMAP_ADDR_W'(1);
`endif

  assign m_valid = (fifo_count != 2'd0);
  assign pop     = m_valid && bus.m_ready;
  // Credits: buffered beats plus the read still in flight, net of this cycle's pop.
  assign pending = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    last_addr_d = last_addr_q;
    length_d    = length_q;
    issue_cnt_d = issue_cnt_q;
    issue       = 1'b0;
`ifdef FMAP_RD_STRIDE_EN
    stride_d    = stride_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          length_d    = length;
          next_addr_d = base_addr;
          issue_cnt_d = '0;
`ifdef FMAP_RD_STRIDE_EN
          stride_d    = stride;
`endif
          state_d     = (length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (pending <= 3'd1) begin
          issue       = 1'b1;
          last_addr_d = next_addr_q;
          next_addr_d = next_addr_q + cur_stride;
          issue_cnt_d = issue_cnt_q + FMAP_LEN_W'(1);
          if (issue_cnt_q == length_q - FMAP_LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && head.last && (fifo_count == 2'd1) && !inflight_q) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    inflight_d = issue;
    last_tag_d = issue && (issue_cnt_q == length_q - FMAP_LEN_W'(1));
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q     <= IDLE;
      next_addr_q <= '0;
      last_addr_q <= '0;
      length_q    <= '0;
      issue_cnt_q <= '0;
      inflight_q  <= 1'b0;
      last_tag_q  <= 1'b0;
`ifdef FMAP_RD_STRIDE_EN
      stride_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      last_addr_q <= last_addr_d;
      length_q    <= length_d;
      issue_cnt_q <= issue_cnt_d;
      inflight_q  <= inflight_d;
      last_tag_q  <= last_tag_d;
`ifdef FMAP_RD_STRIDE_EN
      stride_q    <= stride_d;
`endif
    end
  end

  assign push_beat.data = {bus.fmap_rd_data_bank_15, bus.fmap_rd_data_bank_14, bus.fmap_rd_data_bank_13,
                           bus.fmap_rd_data_bank_12, bus.fmap_rd_data_bank_11, bus.fmap_rd_data_bank_10,
                           bus.fmap_rd_data_bank_9,  bus.fmap_rd_data_bank_8,  bus.fmap_rd_data_bank_7,
                           bus.fmap_rd_data_bank_6,  bus.fmap_rd_data_bank_5,  bus.fmap_rd_data_bank_4,
                           bus.fmap_rd_data_bank_3,  bus.fmap_rd_data_bank_2,  bus.fmap_rd_data_bank_1,
                           bus.fmap_rd_data_bank_0};
  assign push_beat.last = last_tag_q;

  fmap_rd_skid_fifo u_fifo (
    .clk       (core_clk),
    .rst_n     (core_rst_n),
    .push      (inflight_q),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign bus.fmap_rd_en   = issue;
  assign bus.fmap_rd_addr = issue ? next_addr_q : last_addr_q;
  assign bus.m_valid      = m_valid;
  assign bus.m_data       = head.data;
  assign bus.m_last       = head.last && m_valid;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);

endmodule

// File: tb/tb_fmap_rd_streamer.sv
// Self-checking bench for fmap_rd_streamer: directed and randomized transfers scored
// against a queue model of the expected address walk and beat order.
module tb_fmap_rd_streamer;
  import fmap_pkg::*;

  logic                   core_clk   = 1'b0;
  logic                   core_rst_n = 1'b0;
  logic                   start      = 1'b0;
  logic [FMAP_ADDR_W-1:0] base_addr  = '0;
  logic [FMAP_LEN_W-1:0]  length     = '0;
`ifdef FMAP_RD_STRIDE_EN
  logic [FMAP_ADDR_W-1:0] stride     = '0;
`endif
  logic                   busy;
  logic                   done;
  logic [31:0]            salt       = 32'h0;
  int                     checks     = 0;
  int                     errors     = 0;
  int r_first_rd, r_last_rd, r_reads, r_reads_at_hi, r_first_valid;
  int r_valid_cycles, r_last_cycle, r_beats, r_done_cycle;
  logic [FMAP_BANK_W-1:0] rd_banks [FMAP_NUM_BANKS];

  fmap_rd_streamer_if bus ();

  fmap_rd_streamer dut (
    .core_clk   (core_clk),
    .core_rst_n (core_rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
`ifdef FMAP_RD_STRIDE_EN
    .stride     (stride),
`endif
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 core_clk = ~core_clk;

  function automatic logic [63:0] pattern(input logic [FMAP_ADDR_W-1:0] a, input int k);
    return {salt ^ (32'(k) * 32'h01000193), 15'd0, 4'(k), a};
  endfunction

  // Buffer model: one-cycle read latency, junk on the port whenever no read was issued.
  always @(posedge core_clk) begin
    for (int k = 0; k < FMAP_NUM_BANKS; k++)
      rd_banks[k] <= bus.fmap_rd_en ? pattern(bus.fmap_rd_addr, k) : {$urandom, $urandom};
  end

  assign bus.fmap_rd_data_bank_0  = rd_banks[0];
  assign bus.fmap_rd_data_bank_1  = rd_banks[1];
  assign bus.fmap_rd_data_bank_2  = rd_banks[2];
  assign bus.fmap_rd_data_bank_3  = rd_banks[3];
  assign bus.fmap_rd_data_bank_4  = rd_banks[4];
  assign bus.fmap_rd_data_bank_5  = rd_banks[5];
  assign bus.fmap_rd_data_bank_6  = rd_banks[6];
  assign bus.fmap_rd_data_bank_7  = rd_banks[7];
  assign bus.fmap_rd_data_bank_8  = rd_banks[8];
  assign bus.fmap_rd_data_bank_9  = rd_banks[9];
  assign bus.fmap_rd_data_bank_10 = rd_banks[10];
  assign bus.fmap_rd_data_bank_11 = rd_banks[11];
  assign bus.fmap_rd_data_bank_12 = rd_banks[12];
  assign bus.fmap_rd_data_bank_13 = rd_banks[13];
  assign bus.fmap_rd_data_bank_14 = rd_banks[14];
  assign bus.fmap_rd_data_bank_15 = rd_banks[15];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_rd_en"}, bus.fmap_rd_en, 0);
    checkOutput({tag, "_rd_addr"}, 64'(bus.fmap_rd_addr), 0);
    checkOutput({tag, "_m_valid"}, bus.m_valid, 0);
    checkOutput({tag, "_m_last"}, bus.m_last, 0);
    checkOutput({tag, "_m_data_zero"}, bus.m_data == '0, 1);
  endtask

  // One transfer: start in cycle 0, optional stall window, restart pulse or mid-transfer reset.
  task automatic applyStimulus(input string name, input logic [FMAP_ADDR_W-1:0] b,
                               input logic [FMAP_LEN_W-1:0] len, input logic [FMAP_ADDR_W-1:0] strd,
                               input int stall_lo, input int stall_hi, input bit rand_ready,
                               input int restart_at, input int reset_at);
    logic [FMAP_ADDR_W-1:0] exp_rd [$];
    logic [FMAP_ADDR_W-1:0] exp_beat [$];
    logic [FMAP_ADDR_W-1:0] a;
    int budget, last_hs;
    bit saw_done;
    a = b;
    for (int i = 0; i < int'(len); i++) begin
      exp_rd.push_back(a);
      exp_beat.push_back(a);
      a = a + strd;
    end
    budget = 8 * int'(len) + (stall_hi - stall_lo) + 40;
    r_first_rd = -1; r_last_rd = -1; r_reads = 0; r_reads_at_hi = -1; r_first_valid = -1;
    r_valid_cycles = 0; r_last_cycle = -1; r_beats = 0; r_done_cycle = -1;
    last_hs = 0; saw_done = 1'b0;
    @(posedge core_clk); #1;
    base_addr = b;
    length    = len;
`ifdef FMAP_RD_STRIDE_EN
    stride    = strd;
`endif
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (cyc > 0) begin @(posedge core_clk); #1; end
      start = (cyc == 0) || (cyc == restart_at);
      if (cyc == restart_at) begin
        base_addr = ~b;
        length    = FMAP_LEN_W'(3);
`ifdef FMAP_RD_STRIDE_EN
        stride    = strd + FMAP_ADDR_W'(5);
`endif
      end
      if (cyc >= stall_lo && cyc <= stall_hi) bus.m_ready = 1'b0;
      else bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == reset_at) begin
        start = 1'b0;
        core_rst_n = 1'b0;
        #1;
        checkIdleOutputs({name, "_in_reset"});
        repeat (2) begin
          @(negedge core_clk);
          checkOutput({name, "_no_done_in_reset"}, done, 0);
        end
        @(posedge core_clk); #1;
        core_rst_n = 1'b1;
        repeat (3) begin
          @(negedge core_clk);
          checkOutput({name, "_post_busy"}, busy, 0);
          checkOutput({name, "_post_done"}, done, 0);
          checkOutput({name, "_post_m_valid"}, bus.m_valid, 0);
        end
        return;
      end
      @(negedge core_clk);
      if (bus.fmap_rd_en) begin
        r_reads++;
        if (r_first_rd < 0) r_first_rd = cyc;
        r_last_rd = cyc;
        checkOutput({name, "_read_count_ok"}, r_reads <= int'(len), 1);
        if (exp_rd.size() > 0) checkOutput({name, "_rd_addr"}, 64'(bus.fmap_rd_addr), 64'(exp_rd.pop_front()));
      end
      if (bus.m_valid) begin
        r_valid_cycles++;
        if (r_first_valid < 0) r_first_valid = cyc;
        if (bus.m_last) r_last_cycle = cyc;
        checkOutput({name, "_beat_expected"}, exp_beat.size() > 0, 1);
        if (exp_beat.size() > 0) begin
          for (int k = 0; k < FMAP_NUM_BANKS; k++)
            checkOutput($sformatf("%s_bank%0d", name, k), bus.m_data[64*k +: 64], pattern(exp_beat[0], k));
          checkOutput({name, "_m_last"}, bus.m_last, exp_beat.size() == 1);
          if (bus.m_ready) begin
            void'(exp_beat.pop_front());
            r_beats++;
            last_hs = cyc;
          end
        end
      end
      if (cyc == stall_hi) r_reads_at_hi = r_reads;
      if (bus.fmap_rd_en) checkOutput({name, "_credit"}, (r_reads - r_beats) <= 2, 1);
      if (done) begin
        r_done_cycle = cyc;
        saw_done = 1'b1;
        checkOutput({name, "_done_cycle"}, cyc, (len == '0) ? 1 : last_hs + 1);
        checkOutput({name, "_all_beats"}, exp_beat.size(), 0);
        checkOutput({name, "_busy_at_done"}, busy, 1);
      end else if (saw_done) begin
        checkOutput({name, "_busy_after_done"}, busy, 0);
        break;
      end else begin
        checkOutput({name, "_busy"}, busy, cyc >= 1);
      end
    end
    checkOutput({name, "_done_seen"}, saw_done, 1);
    start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [FMAP_ADDR_W-1:0] rb, rs;
    logic [FMAP_LEN_W-1:0]  rl;
    bus.m_ready = 1'b0;
    salt = $urandom;
    #2;
    checkIdleOutputs("por");
    repeat (3) @(posedge core_clk);
    #1 core_rst_n = 1'b1;

    applyStimulus("stream", 13'h0010, 14'd4, 13'd1, -1, -1, 1'b0, -1, -1);
    checkOutput("stream_first_rd", r_first_rd, 1);
    checkOutput("stream_last_rd", r_last_rd, 4);
    checkOutput("stream_reads", r_reads, 4);
    checkOutput("stream_first_valid", r_first_valid, 3);
    checkOutput("stream_valid_cycles", r_valid_cycles, 4);
    checkOutput("stream_last_cycle", r_last_cycle, 6);
    checkOutput("stream_done_cycle", r_done_cycle, 7);

    applyStimulus("bp", salt[12:0], 14'd8, 13'd1, 3, 12, 1'b0, -1, -1);
    checkOutput("bp_reads_during_stall", r_reads_at_hi, 2);
    checkOutput("bp_first_valid", r_first_valid, 3);
    checkOutput("bp_beats", r_beats, 8);
    checkOutput("bp_reads", r_reads, 8);

    applyStimulus("wrap", 13'h1FFE, 14'd4, 13'd1, -1, -1, 1'b0, -1, -1);
    checkOutput("wrap_beats", r_beats, 4);
`ifdef FMAP_RD_STRIDE_EN
    applyStimulus("stride3", 13'h0000, 14'd4, 13'd3, -1, -1, 1'b0, -1, -1);
    checkOutput("stride3_beats", r_beats, 4);
    applyStimulus("stride0", 13'h0ABC, 14'd3, 13'd0, -1, -1, 1'b0, -1, -1);
    checkOutput("stride0_beats", r_beats, 3);
`endif

    applyStimulus("len0", salt[28:16], 14'd0, 13'd1, -1, -1, 1'b0, -1, -1);
    checkOutput("len0_done_cycle", r_done_cycle, 1);
    checkOutput("len0_reads", r_reads, 0);
    checkOutput("len0_valid_cycles", r_valid_cycles, 0);

    applyStimulus("restart", 13'h0100, 14'd4, 13'd1, -1, -1, 1'b0, 2, -1);
    checkOutput("restart_beats", r_beats, 4);
    checkOutput("restart_done_cycle", r_done_cycle, 7);

    for (int t = 0; t < 6; t++) begin
      rb = FMAP_ADDR_W'($urandom);
      rl = FMAP_LEN_W'($urandom_range(1, 24));
`ifdef FMAP_RD_STRIDE_EN
      rs = FMAP_ADDR_W'($urandom);
`else
      rs = FMAP_ADDR_W'(1);
`endif
      applyStimulus($sformatf("rand%0d", t), rb, rl, rs, -1, -1, 1'b1, -1, -1);
      checkOutput($sformatf("rand%0d_beats", t), r_beats, int'(rl));
    end

    applyStimulus("reset_mid", 13'h0200, 14'd6, 13'd1, -1, -1, 1'b0, -1, 3);
    applyStimulus("post_reset", 13'h0300, 14'd2, 13'd1, -1, -1, 1'b0, -1, -1);
    checkOutput("post_reset_beats", r_beats, 2);
    checkOutput("post_reset_first_valid", r_first_valid, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmap_rd_streamer.md
# fmap_rd_streamer

Read-side sequencer for the 16-bank feature-map buffer. On `start` it walks a contiguous (optionally strided) address range, drives the buffer's shared read port, and absorbs the buffer's 1-cycle read latency. Each 16×64-bit read is repackaged as one 1024-bit beat on a valid/ready stream toward the compute array. Backpressure is handled by a 2-entry credit-guarded FIFO, so no read is ever issued without room to land it.

## Interface
- ADDR_W, 13, buffer word-address width
- BANK_W, 64, bits per bank
- NUM_BANKS, 16, banks read in parallel
- core_clk  in  1  sole clock
- core_rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first word address, latched on accepted start
- length  in  ADDR_W+1  words to read, 0..8192, latched on accepted start
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive
- done  out  1  one-cycle pulse at end of transfer
- fmap_rd_en  out  1  buffer read enable
- fmap_rd_addr  out  ADDR_W  buffer read address
- fmap_rd_data_bank_0 … fmap_rd_data_bank_15  in  BANK_W each  buffer read data, valid the cycle after fmap_rd_en
- m_valid  out  1  beat valid
- m_ready  in  1  beat accepted when m_valid && m_ready
- m_data  out  NUM_BANKS*BANK_W  bank k at [64k+63:64k]
- m_last  out  1  high on the final beat of a transfer

## Operation
- Reset values: busy=0, done=0, fmap_rd_en=0, fmap_rd_addr=0, m_valid=0, m_last=0, m_data=0. Reset also clears the FIFO, in-flight flag and counters.
- States:
  - IDLE: start with length≠0 goes to RUN; start with length=0 goes to DONE.
  - RUN: issues reads; moves to DRAIN in the cycle after the last read issues.
  - DRAIN: waits until the FIFO is empty, no read is in flight and the final handshake has occurred, then goes to DONE.
  - DONE: asserts done for one cycle, then returns to IDLE.
- Issue rule: a read issues in RUN when (FIFO occupancy + in-flight − pop_this_cycle) ≤ 1. Occupancy is 0..2; in-flight is 0..1.
- Address i = (base_addr + i·stride) mod 2^13. Arithmetic is 13-bit and wraps silently.
- The read beat is written into the FIFO the cycle after the matching fmap_rd_en. The beat carries a last tag, asserted when i = length−1.
- m_data and m_last come from the FIFO head and are held stable while m_valid && !m_ready.
- start while busy is ignored; base_addr and length are not re-latched.
- fmap_rd_addr holds its last value when fmap_rd_en=0.

## Timing
- start is high in cycle 0. fmap_rd_en is first high in cycle 1 with addr=base. Data appears on the buffer port in cycle 2. m_valid is first high in cycle 3.
- With m_ready held high: one read and one beat per cycle, zero bubbles.
- done is high in the cycle after the final handshake. busy drops the following cycle.
- length=0: done is high in cycle 1, with no fmap_rd_en and no m_valid.
- m_ready deasserted: at most 2 beats are buffered and reads stall. Issue resumes in the same cycle a pop occurs.
- Asynchronous reset mid-transfer: outputs go to reset values immediately. The partial transfer is discarded with no done pulse.

## Configuration
- FMAP_RD_STRIDE_EN defined:
  - adds input `stride` (ADDR_W), latched on accepted start;
  - stride 0 re-reads base_addr length times.
- Undefined: no stride port; stride is fixed at 1.

## Structure
- Package fmap_pkg holds:
  - FMAP_ADDR_W=13, FMAP_BANK_W=64, FMAP_NUM_BANKS=16, FMAP_DEPTH=8192;
  - typedef fmap_beat_t (1024-bit data + last);
  - state enum {IDLE, RUN, DRAIN, DONE}.
- Sub-module fmap_rd_skid_fifo: 2-entry fmap_beat_t FIFO with push, pop and occupancy count. The top level holds the FSM, address counter, issue counter and in-flight flag.

## Test plan
- Reset: assert core_rst_n=0 mid-simulation -> all outputs 0 in the same cycle; after release, IDLE with busy=0.
- Streaming: base=0x0010, length=4, m_ready=1 ->
  - fmap_rd_en in cycles 1–4 with addrs 0x10..0x13;
  - m_valid in cycles 3–6 with bank k data matching the preloaded pattern;
  - m_last in cycle 6, done in cycle 7.
- Backpressure: length=8, m_ready=0 for cycles 3–12 -> only 2 reads issued, m_data stable. Release m_ready -> all 8 beats arrive in order, no duplicates or losses.
- Wrap: base=0x1FFE, length=4 -> addrs 0x1FFE, 0x1FFF, 0x0000, 0x0001. With FMAP_RD_STRIDE_EN and stride=3, base=0 -> addrs 0, 3, 6, 9.
- length=0 -> done in cycle 1, fmap_rd_en and m_valid never asserted.
- start pulsed again in cycle 2 of a length=4 transfer -> ignored, exactly 4 beats delivered. Reset applied in cycle 3 of a second transfer -> no done pulse, FIFO empty afterwards.
